// File: rtl/math_wb_stage.sv
// ---------------------------------------------------------------------------
// math_wb_stage
//
// Registered output stage behind the combinational math unit. Captures the
// result/flag/opcode triple with a valid/ready handshake and holds it in a
// 2-entry skid buffer (main + skid). The producer-side ready is a flop, so a
// stalled consumer never reaches back into the math unit's timing path.
// The stage also watches accepted DIV/REM results for divide-by-zero.
//
// Optional feature macro: MATH_WB_STATUS_EN
//   defined     -> sticky_div_zero / div_zero_cnt / status_clr are built
//   not defined -> status outputs tie to 0, status_clr is ignored
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready producer handshake (in_ready registered)
//   in_result/flag/op math unit result, carry/borrow or div_zero flag, opcode
//   out_valid/ready   consumer handshake on the head entry
//   out_result/flag/op head entry contents (flag passed unchanged)
//   status_clr        synchronous clear of sticky status
//   sticky_div_zero   set by any accepted DIV/REM carrying flag=1
//   div_zero_cnt      saturating count of those events
// ---------------------------------------------------------------------------
module math_wb_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_flag,
    input  logic [4:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_flag,
    output logic [4:0]       out_op,
    input  logic             status_clr,
    output logic             sticky_div_zero,
    output logic [CNT_W-1:0] div_zero_cnt
);

    // Occupancy of the two-entry buffer.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   main_result_q, main_result_d;
    logic               main_flag_q, main_flag_d;
    logic [4:0]         main_op_q, main_op_d;
    logic [WIDTH-1:0]   skid_result_q, skid_result_d;
    logic               skid_flag_q, skid_flag_d;
    logic [4:0]         skid_op_q, skid_op_d;

    logic               accept_s;
    logic               deliver_s;

    assign accept_s  = in_valid & in_ready_q;
    assign deliver_s = out_valid_q & out_ready;

    // Next-state and data-movement decode for the skid buffer; in_* is only
    // sampled on accept so undefined data with in_valid=0 never enters.
    always_comb begin
        state_d       = state_q;
        main_result_d = main_result_q;
        main_flag_d   = main_flag_q;
        main_op_d     = main_op_q;
        skid_result_d = skid_result_q;
        skid_flag_d   = skid_flag_q;
        skid_op_d     = skid_op_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d       = ST_ONE;
                    main_result_d = in_result;
                    main_flag_d   = in_flag;
                    main_op_d     = in_op;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && deliver_s) begin
                    state_d       = ST_ONE;
                    main_result_d = in_result;
                    main_flag_d   = in_flag;
                    main_op_d     = in_op;
                end else if (accept_s) begin
                    // Head is stalled: park the new entry behind it.
                    state_d       = ST_TWO;
                    skid_result_d = in_result;
                    skid_flag_d   = in_flag;
                    skid_op_d     = in_op;
                end else if (deliver_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_TWO: begin
                if (deliver_s) begin
                    state_d       = ST_ONE;
                    main_result_d = skid_result_q;
                    main_flag_d   = skid_flag_q;
                    main_op_d     = skid_op_q;
                end else begin
                    state_d = ST_TWO;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Handshake outputs are registered from the next occupancy.
        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Buffer state, handshake flags and entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_EMPTY;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            main_result_q <= {WIDTH{1'b0}};
            main_flag_q   <= 1'b0;
            main_op_q     <= 5'd0;
            skid_result_q <= {WIDTH{1'b0}};
            skid_flag_q   <= 1'b0;
            skid_op_q     <= 5'd0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            main_result_q <= main_result_d;
            main_flag_q   <= main_flag_d;
            main_op_q     <= main_op_d;
            skid_result_q <= skid_result_d;
            skid_flag_q   <= skid_flag_d;
            skid_op_q     <= skid_op_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = main_result_q;
    assign out_flag   = main_flag_q;
    assign out_op     = main_op_q;

`ifdef MATH_WB_STATUS_EN
    // Only DIV (10001) and REM (10010) use the flag as div_zero; for ADD/SUB
    // it is carry/borrow and must not touch status.
    localparam logic [4:0]       OP_DIV  = 5'b10001;
    localparam logic [4:0]       OP_REM  = 5'b10010;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_base_s;
    logic             dz_event_s;

    assign dz_event_s = accept_s & is_div_op(in_op) & in_flag;

    // Clear is applied first so a same-cycle event still counts as one.
    always_comb begin
        cnt_base_s = status_clr ? {CNT_W{1'b0}} : cnt_q;
        sticky_d   = (status_clr ? 1'b0 : sticky_q) | dz_event_s;
        if (dz_event_s && (cnt_base_s != CNT_MAX)) begin
            cnt_d = cnt_base_s + CNT_ONE;
        end else begin
            cnt_d = cnt_base_s;
        end
    end

    // Sticky divide-by-zero status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign sticky_div_zero = sticky_q;
    assign div_zero_cnt    = cnt_q;
`else
    logic unused_status_clr_s;
    assign unused_status_clr_s = status_clr;
    assign sticky_div_zero     = 1'b0;
    assign div_zero_cnt        = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_math_wb_stage.sv
module tb_math_wb_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 2;
    localparam logic [4:0] OP_ADD  = 5'b01101;
    localparam logic [4:0] OP_SUB  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_MULH = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b10001;
    localparam logic [4:0] OP_REM  = 5'b10010;
`ifdef MATH_WB_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_flag;
    logic [4:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_flag;
    logic [4:0]       out_op;
    logic             status_clr;
    logic             sticky_div_zero;
    logic [CNT_W-1:0] div_zero_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [37:0] exp_q[$];

    math_wb_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flag(in_flag), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flag(out_flag), .out_op(out_op),
        .status_clr(status_clr),
        .sticky_div_zero(sticky_div_zero), .div_zero_cnt(div_zero_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: record accepts, compare deliveries (sampled mid-cycle).
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_spurious", {26'd0, out_flag, out_op, out_result}, 64'hdead);
                end else begin
                    chk("sb_data", {26'd0, out_flag, out_op, out_result}, {26'd0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({in_flag, in_op, in_result});
            end
        end
    end

    // Entries in flight are discarded by reset.
    always @(negedge rst_n) begin
        exp_q.delete();
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one item and hold it until accepted (bounded).
    task automatic push_item(input logic [WIDTH-1:0] r, input logic f, input logic [4:0] op);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_result = r;
        in_flag   = f;
        in_op     = op;
        for (int k = 0; k < 20; k++) begin
            if (!done) begin
                if (in_ready) done = 1'b1;
                cycle();
            end
        end
        if (!done) chk("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_result = 'x;
        in_flag   = 1'b0;
        in_op     = 5'd0;
    endtask

    task automatic chk_status(input string tag, input logic s, input logic [CNT_W-1:0] c);
        chk({tag, "_sticky"}, {63'd0, sticky_div_zero}, STATUS_EN ? {63'd0, s} : 64'd0);
        chk({tag, "_cnt"}, {62'd0, div_zero_cnt}, STATUS_EN ? {62'd0, c} : 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_result  = '0;
        in_flag    = 1'b0;
        in_op      = 5'd0;
        out_ready  = 1'b0;
        status_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_result", {32'd0, out_result}, 64'd0);
        chk("rst_out_op", {59'd0, out_op}, 64'd0);
        chk_status("rst", 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // Single ADD, one-cycle latency, then back to empty.
        out_ready = 1'b1;
        push_item(32'h0000_0005, 1'b0, OP_ADD);
        idle();
        chk("t1_out_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_out_result", {32'd0, out_result}, 64'd5);
        chk("t1_out_op", {59'd0, out_op}, {59'd0, OP_ADD});
        cycle();
        chk("t1_empty", {63'd0, out_valid}, 64'd0);
        chk("t1_in_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back stream with no gaps.
        for (int i = 1; i <= 8; i++) begin
            push_item(WIDTH'(i), 1'b0, OP_MUL);
            chk("t2_in_ready", {63'd0, in_ready}, 64'd1);
            chk("t2_out_valid", {63'd0, out_valid}, 64'd1);
            chk("t2_out_result", {32'd0, out_result}, 64'(i));
        end
        idle();
        cycle();
        chk("t2_drained", 64'(exp_q.size()), 64'd0);

        // Stalled consumer: A,B fill the buffer, C waits.
        out_ready = 1'b0;
        push_item(32'hAAAA_0001, 1'b1, OP_ADD);
        push_item(32'hBBBB_0002, 1'b0, OP_SUB);
        chk("t3_full", {63'd0, in_ready}, 64'd0);
        in_valid  = 1'b1;
        in_result = 32'hCCCC_0003;
        in_flag   = 1'b1;
        in_op     = OP_MULH;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t3_hold_ready", {63'd0, in_ready}, 64'd0);
            chk("t3_hold_data", {32'd0, out_result}, 64'hAAAA_0001);
        end
        out_ready = 1'b1;
        push_item(32'hCCCC_0003, 1'b1, OP_MULH);
        idle();
        repeat (3) cycle();
        chk("t3_drained", 64'(exp_q.size()), 64'd0);

        // Divide-by-zero status.
        for (int k = 1; k <= 3; k++) begin
            push_item(WIDTH'(k), 1'b1, OP_DIV);
            chk_status("t4_div", 1'b1, CNT_W'(k));
        end
        status_clr = 1'b1;
        push_item(32'h0, 1'b1, OP_REM);
        status_clr = 1'b0;
        chk_status("t4_clr_evt", 1'b1, 2'd1);
        push_item(32'h0, 1'b1, OP_SUB);
        chk_status("t4_sub", 1'b1, 2'd1);
        push_item(32'h0, 1'b1, OP_MUL);
        chk_status("t4_mul", 1'b1, 2'd1);
        push_item(32'h7, 1'b0, OP_DIV);
        chk_status("t4_div_ok", 1'b1, 2'd1);
        idle();
        status_clr = 1'b1;
        cycle();
        status_clr = 1'b0;
        chk_status("t4_clr", 1'b0, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            push_item(WIDTH'(k), 1'b1, (k % 2 == 0) ? OP_REM : OP_DIV);
            chk_status("t4_sat", 1'b1, (k > 3) ? 2'd3 : CNT_W'(k));
        end
        push_item(32'h1234_5678, 1'b1, 5'b11111);
        idle();
        repeat (2) cycle();
        chk("t4_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while the buffer is full.
        out_ready = 1'b0;
        push_item(32'h0, 1'b1, OP_DIV);
        push_item(32'h55, 1'b1, OP_ADD);
        idle();
        chk("t5_full", {63'd0, in_ready}, 64'd0);
        chk("t5_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("t5_rst_ready", {63'd0, in_ready}, 64'd1);
        chk("t5_rst_result", {32'd0, out_result}, 64'd0);
        chk("t5_rst_flag", {63'd0, out_flag}, 64'd0);
        chk("t5_rst_op", {59'd0, out_op}, 64'd0);
        chk_status("t5_rst", 1'b0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        cycle();
        push_item(32'h0000_A5A5, 1'b0, OP_REM);
        idle();
        chk("t5_after_result", {32'd0, out_result}, 64'hA5A5);
        chk("t5_after_valid", {63'd0, out_valid}, 64'd1);
        repeat (2) cycle();
        chk("t5_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
